// File: rtl/cart_bus_capture.sv
// Cartridge-bus capture front-end: synchronises and de-glitches the async strobes,
// detects qualified write strobes and queues address/extra bits in a FWFT FIFO.
module cart_bus_capture #(
  parameter int ADDR_W         = 8,
  parameter int EXTRA_W        = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 3,
  parameter int DEPTH          = 4,
  parameter bit CS_ACTIVE_HIGH = 1'b1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               wr_n_i,
  input  logic               cs_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [EXTRA_W-1:0] extra_i,
  input  logic               busy_i,
  output logic               cap_valid_o,
  input  logic               cap_ready_i,
  output logic [ADDR_W-1:0]  cap_addr_o,
  output logic [EXTRA_W-1:0] cap_extra_o,
  output logic               ldq_o,
  output logic               overflow_o,
  output logic [7:0]         evt_count_o
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WORD_W = ADDR_W + EXTRA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);
  localparam logic CS_IDLE = ~CS_ACTIVE_HIGH;
  // Channel 0 is wr_n, channel 1 is cs.
  localparam logic [1:0] FILT_RST = {CS_IDLE, 1'b1};
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [ADDR_W-1:0]      addr_sync_q [SYNC_STAGES];
  logic [ADDR_W-1:0]      addr_sync_d [SYNC_STAGES];
  logic [EXTRA_W-1:0]     extra_sync_q [SYNC_STAGES];
  logic [EXTRA_W-1:0]     extra_sync_d [SYNC_STAGES];

  logic [1:0]       s_vec;
  logic [1:0]       filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic             wr_prev_q, wr_prev_d;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic              ldq_q, ldq_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        evt_q, evt_d;

  logic              event_w, pop_w, push_w, full_w;
  logic [WORD_W-1:0] push_word;

  always_comb begin
    wr_sync_d = {wr_sync_q[SYNC_STAGES-2:0], wr_n_i};
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], cs_i};
    addr_sync_d[0]  = addr_i;
    extra_sync_d[0] = extra_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      addr_sync_d[i]  = addr_sync_q[i-1];
      extra_sync_d[i] = extra_sync_q[i-1];
    end
  end

  // A channel only flips after FILTER_LEN consecutive samples that disagree with it.
  always_comb begin
    s_vec  = {cs_sync_q[SYNC_STAGES-1], wr_sync_q[SYNC_STAGES-1]};
    filt_d = filt_q;
    for (int c = 0; c < 2; c++) begin
      cnt_d[c] = cnt_q[c];
      if (s_vec[c] == filt_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == CNT_MAX) begin
        filt_d[c] = s_vec[c];
        cnt_d[c]  = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
    wr_prev_d = filt_q[0];
  end

  always_comb begin
    event_w    = wr_prev_q & ~filt_q[0] & (filt_q[1] == CS_ACTIVE_HIGH);
    push_word  = {addr_sync_q[SYNC_STAGES-1], extra_sync_q[SYNC_STAGES-1]};
    full_w     = (count_q == FULL_CNT);
    pop_w      = (count_q != '0) & cap_ready_i;
    push_w     = event_w & (~full_w | pop_w);
    overflow_d = overflow_q | (event_w & full_w & ~pop_w);
    evt_d      = evt_q + 8'(event_w);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_w);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_w);
    count_d    = count_q;
    if (push_w && !pop_w) begin
      count_d = count_q + 1'b1;
    end else if (!push_w && pop_w) begin
      count_d = count_q - 1'b1;
    end
    // The head slot may be the one being written this edge, so bypass the memory then.
    head_d = head_q;
    if (count_d != '0) begin
      if (push_w && (rd_ptr_d == wr_ptr_q)) begin
        head_d = push_word;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
    ldq_d = (count_d == '0) & ~busy_i;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_sync_q  <= '1;
      cs_sync_q  <= {SYNC_STAGES{CS_IDLE}};
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync_q[i]  <= '0;
        extra_sync_q[i] <= '0;
      end
      filt_q     <= FILT_RST;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      wr_prev_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      ldq_q      <= 1'b0;
      overflow_q <= 1'b0;
      evt_q      <= '0;
    end else begin
      wr_sync_q  <= wr_sync_d;
      cs_sync_q  <= cs_sync_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync_q[i]  <= addr_sync_d[i];
        extra_sync_q[i] <= extra_sync_d[i];
      end
      filt_q     <= filt_d;
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
      wr_prev_q  <= wr_prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      ldq_q      <= ldq_d;
      overflow_q <= overflow_d;
      evt_q      <= evt_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign cap_valid_o = (count_q != '0);
  assign cap_addr_o  = head_q[WORD_W-1:EXTRA_W];
  assign cap_extra_o = head_q[EXTRA_W-1:0];
  assign ldq_o       = ldq_q;
  assign overflow_o  = overflow_q;
  assign evt_count_o = evt_q;

endmodule

// File: tb/tb_cart_bus_capture.sv
// Scoreboard bench for cart_bus_capture: a cycle-level reference model queues the
// expected captures, and a negedge monitor checks pops and status outputs.
module tb_cart_bus_capture;
  localparam int ADDR_W         = 8;
  localparam int EXTRA_W        = 1;
  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 3;
  localparam int DEPTH          = 4;
  localparam bit CS_ACTIVE_HIGH = 1'b1;
  localparam int LATENCY        = SYNC_STAGES + FILTER_LEN + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_i = 1'b1;
  logic               wr_n_i = 1'b1;
  logic               cs_i = CS_ACTIVE_HIGH;
  logic [ADDR_W-1:0]  addr_i = '0;
  logic [EXTRA_W-1:0] extra_i = '0;
  logic               busy_i = 1'b0;
  logic               cap_ready_i = 1'b0;
  logic               cap_valid_o;
  logic [ADDR_W-1:0]  cap_addr_o;
  logic [EXTRA_W-1:0] cap_extra_o;
  logic               ldq_o;
  logic               overflow_o;
  logic [7:0]         evt_count_o;

  cart_bus_capture #(
    .ADDR_W(ADDR_W), .EXTRA_W(EXTRA_W), .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN(FILTER_LEN), .DEPTH(DEPTH), .CS_ACTIVE_HIGH(CS_ACTIVE_HIGH)
  ) dut (
    .clock_i(clk), .reset_i(reset_i), .wr_n_i(wr_n_i), .cs_i(cs_i),
    .addr_i(addr_i), .extra_i(extra_i), .busy_i(busy_i),
    .cap_valid_o(cap_valid_o), .cap_ready_i(cap_ready_i),
    .cap_addr_o(cap_addr_o), .cap_extra_o(cap_extra_o), .ldq_o(ldq_o),
    .overflow_o(overflow_o), .evt_count_o(evt_count_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: inputs seen through a delay line, a run-length filter,
  // and a bounded queue of expected captures.
  typedef struct {
    logic [ADDR_W-1:0]  a;
    logic [EXTRA_W-1:0] e;
  } entry_t;

  entry_t             exp_q[$];
  entry_t             mon_e;
  bit                 wr_line[$];
  bit                 cs_line[$];
  logic [ADDR_W-1:0]  addr_line[$];
  logic [EXTRA_W-1:0] ext_line[$];
  bit f_wr, f_cs, prev_f_wr, m_ovf, m_ldq, model_live = 1'b0;
  int run_wr, run_cs, occ, m_evt;

  function automatic void model_reset();
    wr_line = {}; cs_line = {}; addr_line = {}; ext_line = {};
    for (int i = 0; i < SYNC_STAGES; i++) begin
      wr_line.push_back(1'b1);
      cs_line.push_back(!CS_ACTIVE_HIGH);
      addr_line.push_back('0);
      ext_line.push_back('0);
    end
    exp_q = {};
    f_wr = 1'b1; f_cs = !CS_ACTIVE_HIGH; prev_f_wr = 1'b1;
    run_wr = 0; run_cs = 0; occ = 0; m_evt = 0; m_ovf = 1'b0; m_ldq = 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset_i) begin
      model_reset();
    end else begin
      bit s_wr, s_cs, ev, pop;
      entry_t ent;
      s_wr  = wr_line[SYNC_STAGES-1];
      s_cs  = cs_line[SYNC_STAGES-1];
      ent.a = addr_line[SYNC_STAGES-1];
      ent.e = ext_line[SYNC_STAGES-1];
      ev  = prev_f_wr && !f_wr && (f_cs == CS_ACTIVE_HIGH);
      pop = (occ > 0) && cap_ready_i;
      if (ev) begin
        m_evt = (m_evt + 1) % 256;
        if (occ == DEPTH && !pop) m_ovf = 1'b1;
        else begin
          exp_q.push_back(ent);
          occ++;
        end
      end
      if (pop) occ--;
      m_ldq = (occ == 0) && !busy_i;
      prev_f_wr = f_wr;
      if (s_wr != f_wr) begin
        run_wr++;
        if (run_wr == FILTER_LEN) begin f_wr = s_wr; run_wr = 0; end
      end else run_wr = 0;
      if (s_cs != f_cs) begin
        run_cs++;
        if (run_cs == FILTER_LEN) begin f_cs = s_cs; run_cs = 0; end
      end else run_cs = 0;
      wr_line.push_front(wr_n_i);     void'(wr_line.pop_back());
      cs_line.push_front(cs_i);       void'(cs_line.pop_back());
      addr_line.push_front(addr_i);   void'(addr_line.pop_back());
      ext_line.push_front(extra_i);   void'(ext_line.pop_back());
    end
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live && !reset_i) begin
      check("cap_valid", cap_valid_o, occ != 0);
      check("evt_count", evt_count_o, m_evt);
      check("overflow", overflow_o, m_ovf);
      check("ldq", ldq_o, m_ldq);
      if (cap_valid_o && cap_ready_i) begin
        if (exp_q.size() == 0) check("pop_without_expected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("head_addr", cap_addr_o, mon_e.a);
          check("head_extra", cap_extra_o, mon_e.e);
          $display("pop addr=%0h extra=%0h at %0t", cap_addr_o, cap_extra_o, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [ADDR_W-1:0] a, input int low_n);
    addr_i = a;
    wr_n_i = 1'b0;
    idle(low_n);
    wr_n_i = 1'b1;
    idle(8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, cap_valid_o, 0);
    check({tag, "_addr"}, cap_addr_o, 0);
    check({tag, "_extra"}, cap_extra_o, 0);
    check({tag, "_ldq"}, ldq_o, 0);
    check({tag, "_ovf"}, overflow_o, 0);
    check({tag, "_evt"}, evt_count_o, 0);
  endtask

  task automatic measure_latency(input string tag);
    int lat;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!cap_valid_o && lat < 20);
    check(tag, lat, LATENCY);
  endtask

  int e0;
  int hold;

  initial begin
    idle(3);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    idle(4);

    // Latency and head contents.
    addr_i = 8'hA5; extra_i = 1'b1; wr_n_i = 1'b0;
    measure_latency("latency");
    if (LATENCY < 8) idle(8 - LATENCY);
    wr_n_i = 1'b1;
    check("t1_addr", cap_addr_o, 8'hA5);
    check("t1_extra", cap_extra_o, 1);
    check("t1_evt", evt_count_o, 1);
    idle(8);
    cap_ready_i = 1'b1; step(); cap_ready_i = 1'b0;
    idle(2);

    // Glitch rejection at the filter boundary.
    extra_i = 1'b0;
    e0 = evt_count_o;
    pulse(8'h11, FILTER_LEN - 1);
    check("glitch_short", evt_count_o, e0);
    pulse(8'h22, FILTER_LEN);
    check("glitch_exact", evt_count_o, e0 + 1);
    cap_ready_i = 1'b1; idle(2); cap_ready_i = 1'b0;

    // Chip-select qualification.
    e0 = evt_count_o;
    cs_i = !CS_ACTIVE_HIGH;
    pulse(8'h33, 6);
    check("cs_inactive", evt_count_o, e0);
    wr_n_i = 1'b0; idle(8);
    cs_i = CS_ACTIVE_HIGH; idle(8);
    wr_n_i = 1'b1; idle(8);
    check("cs_late", evt_count_o, e0);

    // Overflow with consumer stalled, then in-order drain.
    e0 = evt_count_o;
    for (int a = 1; a <= 5; a++) pulse(ADDR_W'(a), 4);
    check("ovf_set", overflow_o, 1);
    check("ovf_evt", evt_count_o, e0 + 5);
    cap_ready_i = 1'b1; idle(6); cap_ready_i = 1'b0;
    check("drained", cap_valid_o, 0);
    reset_i = 1'b1; step();
    check_reset_outputs("rst_ovf");
    reset_i = 1'b0; idle(3);

    // Full FIFO with a pop aligned to the event cycle.
    for (int a = 0; a < DEPTH; a++) pulse(ADDR_W'(8'h41 + a), 4);
    addr_i = 8'h4F; wr_n_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == LATENCY - 1) cap_ready_i = 1'b1;
      if (k == LATENCY) cap_ready_i = 1'b0;
    end
    wr_n_i = 1'b1; idle(8);
    check("full_pop_ovf", overflow_o, 0);
    check("full_pop_valid", cap_valid_o, 1);
    cap_ready_i = 1'b1; idle(6); cap_ready_i = 1'b0;

    // ldq tracks busy with one cycle of latency while empty.
    for (int i = 0; i < 8; i++) begin
      busy_i = (i % 3 == 1);
      step();
      check("ldq_busy", ldq_o, !busy_i);
    end
    busy_i = 1'b0;

    // Reset with FIFO occupied and wr_n held low through release.
    pulse(8'h5A, 4);
    check("pre_reset_valid", cap_valid_o, 1);
    wr_n_i = 1'b0;
    reset_i = 1'b1; step();
    check_reset_outputs("rst_mid");
    reset_i = 1'b0;
    measure_latency("reset_low_latency");
    check("reset_low_addr", cap_addr_o, 8'h5A);
    wr_n_i = 1'b1; idle(8);
    cap_ready_i = 1'b1; idle(2); cap_ready_i = 1'b0;

    // Randomised traffic against the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold <= 0) begin
        wr_n_i = !wr_n_i;
        hold = $urandom_range(1, 6);
        if (!wr_n_i) begin
          addr_i  = ADDR_W'($urandom);
          extra_i = EXTRA_W'($urandom);
          cs_i    = (($urandom % 8) != 0) ? CS_ACTIVE_HIGH : !CS_ACTIVE_HIGH;
        end
      end
      hold--;
      cap_ready_i = (($urandom % 4) == 0);
      busy_i      = (($urandom % 3) == 0);
      reset_i     = (($urandom % 700) == 0);
      step();
    end
    reset_i = 1'b0; wr_n_i = 1'b1; cap_ready_i = 1'b1;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cart_bus_capture.md
Name: cart_bus_capture

Overview:
Parametrised capture front-end for the cartridge-bus speech interface. It synchronises and de-glitches asynchronous cartridge strobes, detects qualified write strobes, and latches address plus extra data bits into a small first-word-fall-through FIFO for the speech core. It generates the registered load-request (LDQ) line back to the bus. It replaces the ad-hoc single-flop GPIO sampling at the top level, adding configurable sync depth, filtering, buffering, overflow detection and event counting.

Parameters:
ADDR_W, 8, width of captured address bus
EXTRA_W, 1, width of extra captured data bits (e.g. D5)
SYNC_STAGES, 2, synchroniser flops per input; legal range >=2
FILTER_LEN, 3, consecutive differing samples needed before a filtered strobe changes; legal range >=1
DEPTH, 4, FIFO entries; power of two, legal range >=2
CS_ACTIVE_HIGH, 1, polarity of cs_i (1: high = selected)

Ports:
clock_i  in  1  single system clock
reset_i  in  1  synchronous, active-high reset
wr_n_i  in  1  async cartridge write strobe, active low
cs_i  in  1  async cartridge chip select, polarity per CS_ACTIVE_HIGH
addr_i  in  ADDR_W  async address bus
extra_i  in  EXTRA_W  async extra data bits
busy_i  in  1  speech core busy (1 = cannot take command)
cap_valid_o  out  1  FIFO head valid
cap_ready_i  in  1  consumer accepts head this cycle
cap_addr_o  out  ADDR_W  FIFO head address
cap_extra_o  out  EXTRA_W  FIFO head extra bits
ldq_o  out  1  load request to bus (1 = ready for next command)
overflow_o  out  1  sticky: event dropped because FIFO full
evt_count_o  out  8  detected write events, modulo 256

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on clock_i rising edge.
- Reset values: wr_n sync chain all 1; cs sync chain all inactive level; addr/extra chains 0; filtered wr_n = 1; filtered cs = inactive; filter counters 0; FIFO empty; cap_valid_o=0; cap_addr_o=0; cap_extra_o=0; ldq_o=0; overflow_o=0; evt_count_o=0.
- Synchroniser: every input passes through SYNC_STAGES flops; "s" denotes the last stage.
- Filter, applied to wr_n and cs independently:
  - if s == filt, cnt<=0
  - else if cnt == FILTER_LEN-1, filt<=s and cnt<=0
  - else cnt<=cnt+1
  - FILTER_LEN=1 means filt follows s one cycle later.
  - Pulses shorter than FILTER_LEN cycles after sync are fully rejected.
- Event: filt_wr_n_prev==1, filt_wr_n==0 and filt_cs active, in the same cycle.
  - Address/extra are taken from the synced last stage in the event cycle.
  - The FIFO write occurs at the next rising edge.
- Latency: from the first edge sampling wr_n_i low (cs already settled active), cap_valid_o rises after exactly SYNC_STAGES+FILTER_LEN+1 edges (6 with defaults).
- A wr_n rising edge never produces an event. cs deasserting while wr_n stays low produces no event. cs asserting while wr_n is already low produces no event.
- FIFO is first-word fall-through:
  - cap_valid_o = not empty; head is presented on cap_addr_o/cap_extra_o.
  - Pop when cap_valid_o && cap_ready_i.
  - cap_addr_o/cap_extra_o hold their last value when empty.
- Full FIFO with event and pop in the same cycle: push accepted, occupancy unchanged.
- Full FIFO with event and no pop: entry dropped, overflow_o <= 1 until reset, FIFO contents unchanged.
- Empty FIFO with event: push only; pop is impossible that cycle.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits wide.
- evt_count_o increments on every detected event, accepted or dropped, and wraps 255->0.
- ldq_o is registered: ldq_o <= (FIFO empty after this edge's update) && !busy_i. One cycle latency from busy_i.
- Reset mid-operation clears everything, including FIFO contents and overflow.
  - If wr_n_i is held low with cs active across reset release, one event is required after the normal latency, because filt starts at 1.

Test Plan:
- Defaults; cs_i=1; addr_i=0xA5, extra_i=1; wr_n_i low for 8 cycles -> cap_valid_o rises exactly 6 edges after first low sample; head 0xA5/1; evt_count_o=1; ldq_o=0 while entry held.
- wr_n_i low glitch of 2 cycles (FILTER_LEN=3) -> no event, evt_count_o stays 0. Repeat with 3-cycle low -> exactly one event.
- cs_i=0 during wr_n_i pulse -> no capture. cs_i rising while wr_n_i already low -> no capture.
- cap_ready_i=0; 5 write pulses with addr 1..5 (DEPTH=4) -> FIFO holds 1..4; overflow_o=1; evt_count_o=5. Then drain with ready=1 -> outputs 1,2,3,4 in order, then cap_valid_o=0.
- FIFO full with cap_ready_i=1 aligned to an event cycle -> new entry accepted; overflow_o stays 0; order preserved.
- busy_i toggling with FIFO empty -> ldq_o follows !busy_i one cycle late. reset_i pulse with FIFO non-empty -> all outputs return to reset values the next edge.
